// File: rtl/arbitro_mux_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_mux_rr_pkg
//  Purpose  : Shared lane constants, types and helpers for the 4-lane
//             mux/demux transmit scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package arbitro_mux_rr_pkg;

  // Lane count and lane-tag width are fixed by the mux/demux fabric.
  localparam int NUM_LANES      = 4;
  localparam int LANE_SEL_WIDTH = 2;

  // Lane encodings shared by the mux, the demux and the scheduler.
  localparam logic [LANE_SEL_WIDTH-1:0] LANE0 = 2'b00;
  localparam logic [LANE_SEL_WIDTH-1:0] LANE1 = 2'b01;
  localparam logic [LANE_SEL_WIDTH-1:0] LANE2 = 2'b10;
  localparam logic [LANE_SEL_WIDTH-1:0] LANE3 = 2'b11;

  typedef logic [LANE_SEL_WIDTH-1:0] lane_t;

  // One pipeline slot: whether it carries a word, and for which lane.
  typedef struct packed {
    logic  valid;
    lane_t lane;
  } stage_t;

  // Decode a lane index into its pop strobe.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_t idx);
    logic [NUM_LANES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next lane in round-robin order; 3 wraps naturally to 0 in 2 bits.
  function automatic lane_t next_lane(input lane_t idx);
    return idx + lane_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_mux_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_mux_rr_if
//  Purpose  : Bundle of input-FIFO, destination-flag and output-word signals
//             between the scheduler and its surroundings.
//  Revision : 1.0 - initial release
// ============================================================================
interface arbitro_mux_rr_if
  import arbitro_mux_rr_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) ();

  logic                      enb;
  logic [NUM_LANES-1:0]      fifo_empty;
  logic [DATA_WIDTH-1:0]     fifo_data0;
  logic [DATA_WIDTH-1:0]     fifo_data1;
  logic [DATA_WIDTH-1:0]     fifo_data2;
  logic [DATA_WIDTH-1:0]     fifo_data3;
  logic [NUM_LANES-1:0]      dest_almost_full;
  logic [NUM_LANES-1:0]      fifo_pop;
  logic                      salida_valid;
  logic [DATA_WIDTH-1:0]     salida_data;
  logic [LANE_SEL_WIDTH-1:0] salida_sel;
  logic                      idle;

  // Scheduler side.
  modport slave (
    input  enb, fifo_empty, fifo_data0, fifo_data1, fifo_data2, fifo_data3,
           dest_almost_full,
    output fifo_pop, salida_valid, salida_data, salida_sel, idle
  );

  // FIFO / environment side.
  modport master (
    output enb, fifo_empty, fifo_data0, fifo_data1, fifo_data2, fifo_data3,
           dest_almost_full,
    input  fifo_pop, salida_valid, salida_data, salida_sel, idle
  );

endinterface
`default_nettype wire

// File: rtl/arbitro_mux_rr_sel.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_rr_sel
//  Purpose  : Combinational round-robin pick: first eligible lane starting
//             at the pointer and walking upward modulo 4.
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr_sel
  import arbitro_mux_rr_pkg::*;
(
  input  logic [NUM_LANES-1:0] i_eligible,
  input  lane_t                i_ptr,
  output logic                 o_grant_valid,
  output lane_t                o_grant_idx
);

  lane_t w_cand;

  // Walk ptr, ptr+1, ptr+2, ptr+3; the first eligible candidate wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = i_ptr;
    w_cand        = i_ptr;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_cand = i_ptr + lane_t'(k);
      if (!o_grant_valid && i_eligible[w_cand]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_mux_rr
//  Purpose  : Transmit-side round-robin scheduler for the 4-lane mux/demux
//             path. Pops one input FIFO per cycle, captures its word one
//             cycle later and presents it, lane-tagged, the cycle after.
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_mux_rr
  import arbitro_mux_rr_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int SEL_WIDTH  = LANE_SEL_WIDTH
) (
  input  logic               clk,
  input  logic               reset_L,
  arbitro_mux_rr_if.slave    bus
);

  logic [NUM_LANES-1:0]  w_eligible;
  logic                  w_grant_valid;
  lane_t                 w_grant_idx;
  logic [NUM_LANES-1:0]  w_pop;
  logic [DATA_WIDTH-1:0] w_capture;

  lane_t                 r_ptr;
  stage_t                r_stage1;
  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_s2_data;
  logic [SEL_WIDTH-1:0]  r_s2_sel;

  // A lane may be popped only when issuing is enabled, it has data, and its
  // destination can still absorb the words that may already be in flight.
  assign w_eligible = {NUM_LANES{bus.enb}} & ~bus.fifo_empty & ~bus.dest_almost_full;

  arbitro_rr_sel u_sel (
    .i_eligible    (w_eligible),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // Pop strobes are gated by reset so no FIFO is drained while held in reset.
  assign w_pop = (w_grant_valid && reset_L) ? lane_onehot(w_grant_idx) : '0;

  // Round-robin pointer moves past the granted lane; holds when nothing is granted.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_ptr <= LANE0;
    end else if (w_grant_valid) begin
      r_ptr <= next_lane(w_grant_idx);
    end
  end

  // Stage 1 remembers which lane was popped so its data can be picked up next cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_stage1 <= '0;
    end else begin
      r_stage1.valid <= w_grant_valid;
      r_stage1.lane  <= w_grant_idx;
    end
  end

  // 4:1 selection of the FIFO read port belonging to the popped lane.
  always_comb begin
    w_capture = bus.fifo_data0;
    case (r_stage1.lane)
      LANE0: w_capture = bus.fifo_data0;
      LANE1: w_capture = bus.fifo_data1;
      LANE2: w_capture = bus.fifo_data2;
      LANE3: w_capture = bus.fifo_data3;
    endcase
  end

  // Stage 2 registers the word and tag; data/tag hold when no word arrives.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sel   <= '0;
    end else begin
      r_s2_valid <= r_stage1.valid;
      if (r_stage1.valid) begin
        r_s2_data <= w_capture;
        r_s2_sel  <= SEL_WIDTH'(r_stage1.lane);
      end
    end
  end

  assign bus.fifo_pop     = w_pop;
  assign bus.salida_valid = r_s2_valid;
  assign bus.salida_data  = r_s2_data;
  assign bus.salida_sel   = LANE_SEL_WIDTH'(r_s2_sel);
  assign bus.idle         = ~(|w_pop) & ~r_stage1.valid & ~r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_mux_rr
//  Purpose  : Self-checking bench for the round-robin transmit scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_mux_rr;

  logic clk;
  logic reset_L;

  int n_cmp;
  int n_err;

  arbitro_mux_rr_if #(.DATA_WIDTH(4)) bus ();

  arbitro_mux_rr #(.DATA_WIDTH(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Content of input FIFO `l`: the n-th word ever popped from it.
  function automatic logic [3:0] word(input int l, input int n);
    int v;
    v = (14 - l + 5 * n) % 16;
    if (v < 0) v = v + 16;
    return 4'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- input FIFO read ports -----------------------------------
  logic [3:0] fdata [4];
  int         fcnt  [4];
  logic [3:0] pop_n;

  assign bus.fifo_data0 = fdata[0];
  assign bus.fifo_data1 = fdata[1];
  assign bus.fifo_data2 = fdata[2];
  assign bus.fifo_data3 = fdata[3];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop_n[i]) begin
        fdata[i] = word(i, fcnt[i]);
        fcnt[i]++;
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare -------------------
  typedef struct {
    int         lane;
    int         cyc;
    logic [3:0] w;
  } item_t;

  item_t      q[$];
  int         m_ptr;
  int         m_cnt [4];
  logic [3:0] m_last_data;
  int         m_last_sel;
  int         cyc;
  int         g;
  logic [3:0] elig;
  logic [3:0] e_pop;
  logic       e_valid;
  logic       e_idle;

  always @(negedge clk) begin
    g       = -1;
    e_pop   = 4'b0000;
    e_valid = 1'b0;
    if (!reset_L) begin
      q.delete();
      m_ptr       = 0;
      m_last_data = 4'h0;
      m_last_sel  = 0;
      e_idle      = 1'b1;
    end else begin
      elig = {4{bus.enb}} & ~bus.fifo_empty & ~bus.dest_almost_full;
      for (int k = 0; k < 4; k++)
        if (g < 0 && elig[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      if (g >= 0) e_pop[g] = 1'b1;
      e_idle = (e_pop == 4'b0000) && (q.size() == 0);
      if (q.size() > 0 && q[0].cyc == cyc - 2) begin
        e_valid     = 1'b1;
        m_last_data = q[0].w;
        m_last_sel  = q[0].lane;
        void'(q.pop_front());
      end
    end
    chk("m_pop",   32'(bus.fifo_pop),     32'(e_pop));
    chk("m_valid", 32'(bus.salida_valid), 32'(e_valid));
    chk("m_data",  32'(bus.salida_data),  32'(m_last_data));
    chk("m_sel",   32'(bus.salida_sel),   32'(m_last_sel));
    chk("m_idle",  32'(bus.idle),         32'(e_idle));
    pop_n = bus.fifo_pop;
    if (reset_L && g >= 0) begin
      q.push_back('{lane: g, cyc: cyc, w: word(g, m_cnt[g])});
      m_cnt[g]++;
      m_ptr = (g + 1) % 4;
    end
    cyc++;
  end

  // ---------------- directed stimulus with literal pins ----------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_pops(input string name, input logic [3:0] exp_seq [$]);
    foreach (exp_seq[i]) begin
      #1 chk(name, 32'(bus.fifo_pop), 32'(exp_seq[i]));
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    pop_n = 4'b0000;
    m_ptr = 0;
    m_last_data = 4'h0;
    m_last_sel  = 0;
    for (int i = 0; i < 4; i++) begin
      fdata[i] = 4'h0;
      fcnt[i]  = 0;
      m_cnt[i] = 0;
    end
    reset_L              = 1'b0;
    bus.enb              = 1'b0;
    bus.fifo_empty       = 4'hF;
    bus.dest_almost_full = 4'h0;

    #1;
    chk("rst_pop",   32'(bus.fifo_pop),     32'h0);
    chk("rst_valid", 32'(bus.salida_valid), 32'h0);
    chk("rst_idle",  32'(bus.idle),         32'h1);
    tick();
    tick();
    reset_L = 1'b1;
    tick();

    // Full round-robin, all lanes eligible.
    bus.enb        = 1'b1;
    bus.fifo_empty = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_pop", 32'(bus.fifo_pop), 32'(4'b0001 << (k % 4)));
      if (k == 2) begin
        chk("rr_valid0", 32'(bus.salida_valid), 32'h1);
        chk("rr_data0",  32'(bus.salida_data),  32'hE);
        chk("rr_sel0",   32'(bus.salida_sel),   32'h0);
      end
      if (k == 4) begin
        chk("rr_data2", 32'(bus.salida_data), 32'hC);
        chk("rr_sel2",  32'(bus.salida_sel),  32'h2);
      end
      tick();
    end

    // Skip empty lanes 0 and 2, then lane 2 fills after a grant to lane 1.
    bus.fifo_empty = 4'b0101;
    run_pops("skip_pop", '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010});
    bus.fifo_empty = 4'b0001;
    run_pops("fill_pop", '{4'b0100, 4'b1000, 4'b0010});

    // Lane 2 backpressured: never popped; released when the pointer reaches it.
    bus.fifo_empty       = 4'b0000;
    bus.dest_almost_full = 4'b0100;
    run_pops("bp_pop", '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010});
    bus.dest_almost_full = 4'b0000;
    run_pops("bp_rel_pop", '{4'b0100, 4'b1000});

    // enb falls right after the pop of lane 1; two words still drain.
    run_pops("enb_pop", '{4'b0001, 4'b0010});
    bus.enb = 1'b0;
    #1;
    chk("enb_d0_pop",   32'(bus.fifo_pop),     32'h0);
    chk("enb_d0_valid", 32'(bus.salida_valid), 32'h1);
    chk("enb_d0_idle",  32'(bus.idle),         32'h0);
    tick();
    #1;
    chk("enb_d1_valid", 32'(bus.salida_valid), 32'h1);
    chk("enb_d1_sel",   32'(bus.salida_sel),   32'h1);
    tick();
    #1;
    chk("enb_d2_valid", 32'(bus.salida_valid), 32'h0);
    chk("enb_d2_idle",  32'(bus.idle),         32'h1);
    tick();

    // Wrap: only lane 3, then only lane 0.
    bus.enb        = 1'b1;
    bus.fifo_empty = 4'b0111;
    run_pops("wrap3_pop", '{4'b1000});
    bus.fifo_empty = 4'b1110;
    run_pops("wrap0_pop", '{4'b0001});

    // almost_full rises on the lane the pointer would grant: it is skipped.
    bus.fifo_empty       = 4'b0000;
    bus.dest_almost_full = 4'b0010;
    run_pops("af_same_pop", '{4'b0100});
    bus.dest_almost_full = 4'b0000;
    run_pops("pre_rst_pop", '{4'b1000, 4'b0001});

    // Asynchronous reset mid-stream drops in-flight words.
    reset_L = 1'b0;
    #1;
    chk("arst_pop",   32'(bus.fifo_pop),     32'h0);
    chk("arst_valid", 32'(bus.salida_valid), 32'h0);
    chk("arst_data",  32'(bus.salida_data),  32'h0);
    chk("arst_sel",   32'(bus.salida_sel),   32'h0);
    chk("arst_idle",  32'(bus.idle),         32'h1);
    tick();
    tick();
    reset_L = 1'b1;
    #1;
    chk("post_rst_pop",   32'(bus.fifo_pop),     32'h1);
    chk("post_rst_valid", 32'(bus.salida_valid), 32'h0);
    tick();
    #1 chk("post_rst_valid1", 32'(bus.salida_valid), 32'h0);
    tick();
    #1 chk("post_rst_valid2", 32'(bus.salida_valid), 32'h1);
    bus.enb = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
